// File: rtl/mw_writeback_unit.sv
// mw_writeback_unit: register file write-port driver for M/W retirement and multi-cycle mult/div results
module mw_writeback_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int RSTATUS_REG = 30,
   parameter int LINK_REG    = 31
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [31:0]           mw_insn,
   input  logic [DATA_WIDTH-1:0] mw_alu_result,
   input  logic [DATA_WIDTH-1:0] mw_mem_data,
   input  logic [DATA_WIDTH-1:0] mw_pc_plus1,
   input  logic                  mw_ovf,
   input  logic                  x_md_issue,
   input  logic [31:0]           x_insn,
   input  logic                  md_ready,
   input  logic                  md_exception,
   input  logic [DATA_WIDTH-1:0] md_result,
   output logic                  ctrl_writeEnable,
   output logic [4:0]            ctrl_writeReg,
   output logic [DATA_WIDTH-1:0] data_writeReg,
   output logic                  md_stall
);
   localparam logic [4:0] RS_REG = 5'(RSTATUS_REG);
   localparam logic [4:0] LN_REG = 5'(LINK_REG);
   typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;
   state_t                r_state, w_next;
   logic [4:0]            r_md_reg, r_reg;
   logic [DATA_WIDTH-1:0] r_md_data, r_data;
   logic                  r_md_div, r_we, r_stall;
   logic [4:0]            w_op, w_rd, w_alu, w_mw_reg, w_md_dst;
   logic [DATA_WIDTH-1:0] w_mw_data, w_md_val;
   logic                  w_mw_val, w_mw_we, w_md_fire, w_md_wr;
   logic                  w_unused;
   assign w_unused = ^{mw_insn[21:7], mw_insn[1:0], x_insn[31:27], x_insn[21:7], x_insn[1:0]};
   assign w_op  = mw_insn[31:27];
   assign w_rd  = mw_insn[26:22];
   assign w_alu = mw_insn[6:2];
   always_comb begin
      w_mw_val  = 1'b0;
      w_mw_reg  = 5'd0;
      w_mw_data = '0;
      case (w_op)
         5'b00000: if (w_alu != 5'b00110 && w_alu != 5'b00111) begin
            w_mw_val  = 1'b1;
            w_mw_reg  = (mw_ovf && w_alu[4:1] == 4'd0) ? RS_REG : w_rd;
            w_mw_data = (mw_ovf && w_alu[4:1] == 4'd0) ? DATA_WIDTH'(w_alu[0] ? 3 : 1) : mw_alu_result;
         end
         5'b00101: begin
            w_mw_val  = 1'b1;
            w_mw_reg  = mw_ovf ? RS_REG : w_rd;
            w_mw_data = mw_ovf ? DATA_WIDTH'(2) : mw_alu_result;
         end
         5'b01000: begin
            w_mw_val  = 1'b1;
            w_mw_reg  = w_rd;
            w_mw_data = mw_mem_data;
         end
         5'b00011: begin
            w_mw_val  = 1'b1;
            w_mw_reg  = LN_REG;
            w_mw_data = mw_pc_plus1;
         end
         5'b10101: begin
            w_mw_val  = 1'b1;
            w_mw_reg  = RS_REG;
            w_mw_data = mw_alu_result;
         end
         default: ;
      endcase
   end
   assign w_mw_we = w_mw_val && w_mw_reg != 5'd0;
   // In BUSY the result comes straight off the mult/div inputs; in HOLD it is the latched copy
   assign w_md_dst  = (r_state == BUSY && md_exception) ? RS_REG : r_md_reg;
   assign w_md_val  = (r_state != BUSY) ? r_md_data :
                      md_exception ? DATA_WIDTH'(r_md_div ? 5 : 4) : md_result;
   assign w_md_fire = ((r_state == BUSY && md_ready) || r_state == HOLD) && !w_mw_we;
   assign w_md_wr   = w_md_fire && w_md_dst != 5'd0;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = x_md_issue ? BUSY : IDLE;
         BUSY:    w_next = md_ready ? (w_mw_we ? HOLD : IDLE) : BUSY;
         HOLD:    w_next = w_mw_we ? HOLD : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_md_reg  <= 5'd0;
         r_md_data <= '0;
         r_md_div  <= 1'b0;
         r_we      <= 1'b0;
         r_reg     <= 5'd0;
         r_data    <= '0;
         r_stall   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && x_md_issue) begin
            r_md_reg <= x_insn[26:22];
            r_md_div <= x_insn[6:2] == 5'b00111;
         end
         if (r_state == BUSY && md_ready) begin
            r_md_reg  <= w_md_dst;
            r_md_data <= w_md_val;
         end
         r_we    <= w_mw_we || w_md_wr;
         r_reg   <= w_mw_we ? w_mw_reg : w_md_wr ? w_md_dst : 5'd0;
         r_data  <= w_mw_we ? w_mw_data : w_md_wr ? w_md_val : '0;
         r_stall <= w_next != IDLE;
      end
   end
   assign ctrl_writeEnable = r_we;
   assign ctrl_writeReg    = r_reg;
   assign data_writeReg    = r_data;
   assign md_stall         = r_stall;
endmodule

// File: tb/tb_mw_writeback_unit.sv
// tb_mw_writeback_unit: directed bench for the writeback unit
module tb_mw_writeback_unit;
   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] mw_insn, mw_alu_result, mw_mem_data, mw_pc_plus1, x_insn, md_result;
   logic        mw_ovf, x_md_issue, md_ready, md_exception;
   logic        ctrl_writeEnable, md_stall;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   int          checks = 0;
   int          errors = 0;

   mw_writeback_unit dut (
      .clock(clock), .reset(reset), .mw_insn(mw_insn), .mw_alu_result(mw_alu_result),
      .mw_mem_data(mw_mem_data), .mw_pc_plus1(mw_pc_plus1), .mw_ovf(mw_ovf),
      .x_md_issue(x_md_issue), .x_insn(x_insn), .md_ready(md_ready),
      .md_exception(md_exception), .md_result(md_result),
      .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
      .data_writeReg(data_writeReg), .md_stall(md_stall)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
      return {op, rd, 15'd0, alu, 2'b00};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic we, input logic [4:0] rg, input logic [31:0] dt, input logic st);
      chk({tag, ".we"}, {31'd0, ctrl_writeEnable}, {31'd0, we});
      chk({tag, ".reg"}, {27'd0, ctrl_writeReg}, {27'd0, rg});
      chk({tag, ".data"}, data_writeReg, dt);
      chk({tag, ".stall"}, {31'd0, md_stall}, {31'd0, st});
   endtask

   task automatic issue(input logic [4:0] rd, input logic div);
      chk("issue_idle", {31'd0, md_stall}, 32'd0);
      x_md_issue = 1'b1;
      x_insn     = mk(5'b00000, rd, div ? 5'b00111 : 5'b00110);
      tick();
      x_md_issue = 1'b0;
      x_insn     = '0;
   endtask

   initial begin
      reset = 1'b0; mw_insn = '0; mw_alu_result = '0; mw_mem_data = '0; mw_pc_plus1 = '0;
      mw_ovf = 1'b0; x_md_issue = 1'b0; x_insn = '0; md_ready = 1'b0; md_exception = 1'b0; md_result = '0;
      tick(); tick();
      chk_out("reset", 1'b0, 5'd0, 32'd0, 1'b0);
      reset = 1'b1;

      mw_insn = mk(5'b00000, 5'd5, 5'b00000); mw_alu_result = 32'h7;
      tick(); chk_out("add_r5", 1'b1, 5'd5, 32'h7, 1'b0);
      mw_insn = mk(5'b01000, 5'd0, 5'd0); mw_mem_data = 32'hAA;
      tick(); chk_out("lw_r0", 1'b0, 5'd0, 32'd0, 1'b0);
      mw_insn = mk(5'b00000, 5'd5, 5'b00001); mw_ovf = 1'b1; mw_alu_result = 32'h1234;
      tick(); chk_out("sub_ovf", 1'b1, 5'd30, 32'h3, 1'b0);
      mw_insn = mk(5'b00000, 5'd5, 5'b00000);
      tick(); chk_out("add_ovf", 1'b1, 5'd30, 32'h1, 1'b0);
      mw_insn = mk(5'b00101, 5'd7, 5'd0);
      tick(); chk_out("addi_ovf", 1'b1, 5'd30, 32'h2, 1'b0);
      mw_ovf = 1'b0; mw_alu_result = 32'h55;
      tick(); chk_out("addi_r7", 1'b1, 5'd7, 32'h55, 1'b0);
      mw_insn = mk(5'b00011, 5'd0, 5'd0); mw_pc_plus1 = 32'h40;
      tick(); chk_out("jal", 1'b1, 5'd31, 32'h40, 1'b0);
      mw_insn = mk(5'b10101, 5'd0, 5'd0); mw_alu_result = 32'h123;
      tick(); chk_out("setx", 1'b1, 5'd30, 32'h123, 1'b0);
      mw_insn = mk(5'b01000, 5'd6, 5'd0); mw_mem_data = 32'hDEAD;
      tick(); chk_out("lw_r6", 1'b1, 5'd6, 32'hDEAD, 1'b0);
      mw_insn = mk(5'b00000, 5'd8, 5'b00110);
      tick(); chk_out("mw_mul_nowrite", 1'b0, 5'd0, 32'd0, 1'b0);
      mw_insn = mk(5'b00100, 5'd8, 5'd0);
      tick(); chk_out("other_op", 1'b0, 5'd0, 32'd0, 1'b0);
      mw_insn = '0;

      issue(5'd9, 1'b0);
      chk_out("mul_busy0", 1'b0, 5'd0, 32'd0, 1'b1);
      for (int i = 0; i < 16; i++) begin
         tick(); chk_out("mul_busy", 1'b0, 5'd0, 32'd0, 1'b1);
      end
      md_ready = 1'b1; md_result = 32'hFFFF_FFF0;
      tick(); chk_out("mul_done", 1'b1, 5'd9, 32'hFFFF_FFF0, 1'b0);
      md_ready = 1'b0;
      tick(); chk_out("mul_after", 1'b0, 5'd0, 32'd0, 1'b0);

      issue(5'd11, 1'b0);
      tick(); chk_out("col_busy", 1'b0, 5'd0, 32'd0, 1'b1);
      md_ready = 1'b1; md_result = 32'h5A5A; mw_insn = mk(5'b01000, 5'd4, 5'd0); mw_mem_data = 32'h44;
      tick(); chk_out("col_lw", 1'b1, 5'd4, 32'h44, 1'b1);
      md_ready = 1'b0; md_result = 32'h0; mw_insn = mk(5'b00000, 5'd3, 5'b00000); mw_alu_result = 32'h9;
      tick(); chk_out("col_add", 1'b1, 5'd3, 32'h9, 1'b1);
      mw_insn = '0;
      tick(); chk_out("col_md", 1'b1, 5'd11, 32'h5A5A, 1'b0);
      tick(); chk_out("col_after", 1'b0, 5'd0, 32'd0, 1'b0);

      issue(5'd12, 1'b1);
      md_ready = 1'b1; md_exception = 1'b1; md_result = 32'h99;
      tick(); chk_out("div_exc", 1'b1, 5'd30, 32'h5, 1'b0);
      md_ready = 1'b0; md_exception = 1'b0;
      issue(5'd13, 1'b0);
      md_ready = 1'b1; md_exception = 1'b1; mw_insn = mk(5'b00101, 5'd2, 5'd0); mw_alu_result = 32'h77;
      tick(); chk_out("mul_exc_col", 1'b1, 5'd2, 32'h77, 1'b1);
      md_ready = 1'b0; md_exception = 1'b0; mw_insn = '0;
      tick(); chk_out("mul_exc_hold", 1'b1, 5'd30, 32'h4, 1'b0);

      issue(5'd0, 1'b0);
      chk_out("mul_r0_busy", 1'b0, 5'd0, 32'd0, 1'b1);
      md_ready = 1'b1; md_result = 32'h31;
      tick(); chk_out("mul_r0_done", 1'b0, 5'd0, 32'd0, 1'b0);
      md_ready = 1'b0;

      issue(5'd14, 1'b0);
      tick(); chk_out("rst_busy", 1'b0, 5'd0, 32'd0, 1'b1);
      reset = 1'b0;
      tick(); tick();
      chk_out("rst_mid", 1'b0, 5'd0, 32'd0, 1'b0);
      reset = 1'b1; md_ready = 1'b1; md_result = 32'h66;
      tick(); chk_out("rst_ready", 1'b0, 5'd0, 32'd0, 1'b0);
      md_ready = 1'b0;
      tick(); chk_out("rst_after", 1'b0, 5'd0, 32'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
